// File: rtl/fram_spi_ctrl.sv
// SPI master for a 13-bit-address FRAM: single 32-bit word read/write in SPI mode 0.
// Data bytes travel least-significant byte first and each byte is sent MSB first.
module fram_spi_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [12:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        mem_read,
  output logic        mem_write,
  output logic        spi_cs,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  // state  | meaning
  // IDLE   | waiting for a request
  // WREN   | write-enable frame (0x06)
  // GAP    | cs high between WREN and WRITE frames
  // CMD    | read/write opcode
  // ADDR   | 16-bit address
  // DATA   | four data bytes, byte0 first
  // FINISH | done pulse, cs high
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WREN   = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_CMD    = 3'd3;
  localparam logic [2:0] S_ADDR   = 3'd4;
  localparam logic [2:0] S_DATA   = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

  logic [2:0]  state;
  logic        is_write;
  logic [12:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] tx_q;
  logic [31:0] rx_q;
  logic [31:0] rdata_q;
  logic [7:0]  div_cnt;
  logic [7:0]  gap_cnt;
  logic [4:0]  bit_cnt;
  logic        sck_high;
  logic        sck_q;
  logic        mosi_q;
  logic        cs_q;

  logic        accept;
  logic        shifting;
  logic        bit_end;
  logic        frame_end;
  logic        load;
  logic        ld_write;
  logic [2:0]  ld_state;
  logic [31:0] ld_field;
  logic [4:0]  ld_last;

  assign accept    = (state == S_IDLE) && (req_read || req_write);
  assign shifting  = (state == S_WREN) || (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
  assign bit_end   = shifting && (div_cnt == 8'd0) && sck_high;
  assign frame_end = bit_end && (bit_cnt == 5'd0);
  // CMD->ADDR->DATA hand over without a cs or sck gap, so they share the frame-start path
  assign load      = accept || ((state == S_GAP) && (gap_cnt == 8'd0)) ||
                     (frame_end && ((state == S_CMD) || (state == S_ADDR)));

  always_comb begin
    ld_write = (state == S_IDLE) ? req_write : is_write;
    case (state)
      S_IDLE:  ld_state = req_write ? S_WREN : S_CMD;
      S_GAP:   ld_state = S_CMD;
      S_CMD:   ld_state = S_ADDR;
      default: ld_state = S_DATA;
    endcase
    ld_field = 32'h0;
    ld_last  = 5'd0;
    case (ld_state)
      S_WREN: begin
        ld_field = {8'h06, 24'h0};
        ld_last  = 5'd7;
      end
      S_CMD: begin
        ld_field = {(ld_write ? 8'h02 : 8'h03), 24'h0};
        ld_last  = 5'd7;
      end
      S_ADDR: begin
        ld_field = {3'b000, addr_q, 16'h0};
        ld_last  = 5'd15;
      end
      default: begin
        ld_field = ld_write ? {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]} : 32'h0;
        ld_last  = 5'd31;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      is_write <= 1'b0;
      addr_q   <= 13'h0;
      wdata_q  <= 32'h0;
      tx_q     <= 32'h0;
      rx_q     <= 32'h0;
      rdata_q  <= 32'h0;
      div_cnt  <= 8'h0;
      gap_cnt  <= 8'h0;
      bit_cnt  <= 5'h0;
      sck_high <= 1'b0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      cs_q     <= 1'b1;
    end else if (load) begin
      if (state == S_IDLE) begin
        is_write <= req_write;
        addr_q   <= addr;
        wdata_q  <= wdata;
      end
      state    <= ld_state;
      tx_q     <= ld_field;
      mosi_q   <= ld_field[31];
      bit_cnt  <= ld_last;
      div_cnt  <= DIV_LOAD;
      sck_high <= 1'b0;
      sck_q    <= 1'b0;
      cs_q     <= 1'b0;
    end else begin
      case (state)
        S_WREN, S_CMD, S_ADDR, S_DATA: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else if (!sck_high) begin
            sck_q    <= 1'b1;
            sck_high <= 1'b1;
            div_cnt  <= DIV_LOAD;
            if (state == S_DATA) rx_q <= {rx_q[30:0], spi_miso};
          end else if (bit_cnt != 5'd0) begin
            sck_q    <= 1'b0;
            sck_high <= 1'b0;
            div_cnt  <= DIV_LOAD;
            bit_cnt  <= bit_cnt - 5'd1;
            tx_q     <= {tx_q[30:0], 1'b0};
            mosi_q   <= tx_q[30];
          end else begin
            sck_q    <= 1'b0;
            sck_high <= 1'b0;
            mosi_q   <= 1'b0;
            cs_q     <= 1'b1;
            if (state == S_WREN) begin
              state   <= S_GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= S_FINISH;
              if (!is_write) rdata_q <= {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
            end
          end
        end
        S_GAP:    gap_cnt <= gap_cnt - 8'd1;
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FINISH);
  assign mem_read  = busy && !is_write;
  assign mem_write = busy && is_write;
  assign rdata     = rdata_q;
  assign spi_cs    = cs_q;
  assign spi_sck   = sck_q;
  assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_fram_spi_ctrl.sv
// Bench for fram_spi_ctrl: FRAM slave model, protocol checker and a done-driven scoreboard
// comparing frames, read data and device memory against a byte-array reference model.
module tb_fram_spi_ctrl;
  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [12:0] addr = 13'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        busy, done, mem_read, mem_write;
  logic        spi_cs, spi_sck, spi_mosi;
  logic        spi_miso = 1'b0;

  fram_spi_ctrl #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .mem_read(mem_read), .mem_write(mem_write), .spi_cs(spi_cs),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [12:0] a; logic [31:0] d; } txn_t;
  typedef struct { int bits; int low; int gap; logic [79:0] bytes; } frame_t;

  txn_t   exp_q[$];
  frame_t frames[$];
  logic [7:0] ref_mem [8192];
  logic [7:0] dev_mem [8192];
  logic [31:0] last_rd = 32'h0;
  int n_tests = 0;
  int n_fail  = 0;

  // slave/checker state
  logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
  logic [79:0] cur_bytes = '0;
  logic [7:0]  cur_op = 8'h0;
  logic [12:0] cur_a = 13'h0;
  int          cur_bits = 0, lo_cnt = 0, hi_cnt = 0, gap_at_fall = 0, miso_idx = 0;
  bit          wel = 1'b0, skip_frame = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [12:0] a);
    logic [12:0] p;
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      p = a + 13'(k);
      w[8*k +: 8] = ref_mem[p];
    end
    return w;
  endfunction

  always @(negedge clk) begin
    frame_t f;
    logic [12:0] p;
    // protocol rules sampled every cycle
    if (spi_cs === 1'b1 && (spi_sck !== 1'b0 || spi_mosi !== 1'b0)) begin
      n_fail++;
      $display("FAIL idle_lines: sck=%0b mosi=%0b while cs high", spi_sck, spi_mosi);
    end
    if (spi_mosi !== prev_mosi && spi_sck !== 1'b0) begin
      n_fail++;
      $display("FAIL mosi_edge: mosi changed with sck=%0b, required 0", spi_sck);
    end
    if (prev_cs && !spi_cs) begin
      gap_at_fall = hi_cnt; lo_cnt = 1; cur_bits = 0; cur_bytes = '0; cur_op = 8'h0; spi_miso = 1'b0;
    end else if (!spi_cs) lo_cnt++;
    if (!prev_cs && spi_cs) begin
      hi_cnt = 1;
      if (!skip_frame) begin
        n_tests++;
        if (!(cur_bits inside {8, 56, 80})) begin
          n_fail++;
          $display("FAIL frame_bits: got %0d required 8, 56 or 80", cur_bits);
        end
        f.bits = cur_bits; f.low = lo_cnt; f.gap = gap_at_fall; f.bytes = cur_bytes;
        frames.push_back(f);
        if (cur_bits == 8 && cur_op == 8'h06) wel = 1'b1;
        else if (cur_op == 8'h02) wel = 1'b0;
      end
    end else if (spi_cs) hi_cnt++;
    if (!spi_cs && !prev_sck && spi_sck) begin
      cur_bytes = {cur_bytes[78:0], spi_mosi};
      cur_bits++;
      if (cur_bits == 8) cur_op = cur_bytes[7:0];
      if (cur_bits == 24) cur_a = cur_bytes[12:0];
      if (cur_op == 8'h02 && wel && cur_bits > 24 && (cur_bits - 24) % 8 == 0) begin
        p = cur_a + 13'((cur_bits - 32) / 8);
        dev_mem[p] = cur_bytes[7:0];
      end
    end
    if (!spi_cs && prev_sck && !spi_sck && cur_op == 8'h03 && cur_bits >= 24 && cur_bits < 56) begin
      miso_idx = cur_bits - 24;
      p = cur_a + 13'(miso_idx / 8);
      spi_miso = dev_mem[p][7 - (miso_idx % 8)];
    end
    prev_cs = spi_cs; prev_sck = spi_sck; prev_mosi = spi_mosi;

    // scoreboard
    if (done === 1'b1) begin
      txn_t t;
      frame_t f0, f1;
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_done: done=1, required 0 (no transaction pending)");
      end else begin
        t = exp_q.pop_front();
        if (t.wr) begin
          check("write_frame_count", 80'(frames.size()), 80'd2);
          if (frames.size() >= 2) begin
            f0 = frames.pop_front();
            f1 = frames.pop_front();
            check("wren_bits", 80'(f0.bits), 80'd8);
            check("wren_bytes", f0.bytes, 80'h06);
            check("wren_cs_low", 80'(f0.low), 80'(16 * CLK_DIV));
            check("cs_gap", 80'(f1.gap), 80'(CS_GAP));
            check("write_bits", 80'(f1.bits), 80'd56);
            check("write_cs_low", 80'(f1.low), 80'(112 * CLK_DIV));
            check("write_bytes", f1.bytes,
                  {24'h0, 8'h02, 3'b000, t.a, t.d[7:0], t.d[15:8], t.d[23:16], t.d[31:24]});
          end
          for (int k = 0; k < 4; k++) begin
            p = t.a + 13'(k);
            ref_mem[p] = t.d[8*k +: 8];
            check("dev_mem_byte", 80'(dev_mem[p]), 80'(ref_mem[p]));
          end
          check("rdata_held_on_write", 80'(rdata), 80'(last_rd));
        end else begin
          check("read_frame_count", 80'(frames.size()), 80'd1);
          if (frames.size() >= 1) begin
            f0 = frames.pop_front();
            check("read_bits", 80'(f0.bits), 80'd56);
            check("read_cs_low", 80'(f0.low), 80'(112 * CLK_DIV));
            check("read_bytes", f0.bytes, {24'h0, 8'h03, 3'b000, t.a, 32'h0});
          end
          last_rd = ref_word(t.a);
          check("rdata", 80'(rdata), 80'(last_rd));
        end
        frames.delete();
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: busy=%0b after 3000 cycles, required 0", busy);
    end
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [12:0] a, input logic [31:0] d);
    txn_t t;
    wait_idle();
    req_read = rd; req_write = wr; addr = a; wdata = d;
    t.wr = wr; t.a = a; t.d = d;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    req_read = 1'b0; req_write = 1'b0;
    addr = 13'($urandom); wdata = $urandom;
    check("busy_after_accept", 80'(busy), 80'd1);
    check("cs_after_accept", 80'(spi_cs), 80'd0);
    check("mem_write_flag", 80'(mem_write), 80'(wr));
    check("mem_read_flag", 80'(mem_read), 80'(!wr));
  endtask

  initial begin
    logic [12:0] ra;
    int mism;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] ra;
    int mism;
    for (int i = 0; i < 8192; i++) begin
      ref_mem[i] = 8'($urandom);
      dev_mem[i] = ref_mem[i];
    end
    #12;
    check("rst_busy", 80'(busy), 80'd0);
    check("rst_done", 80'(done), 80'd0);
    check("rst_cs", 80'(spi_cs), 80'd1);
    check("rst_sck", 80'(spi_sck), 80'd0);
    check("rst_mosi", 80'(spi_mosi), 80'd0);
    check("rst_mem_read", 80'(mem_read), 80'd0);
    check("rst_mem_write", 80'(mem_write), 80'd0);
    check("rst_rdata", 80'(rdata), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, 1'b1, 13'h0100, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 13'h0100, 32'h0);
    wait_idle();
    check("readback_deadbeef", 80'(rdata), 80'hDEADBEEF);

    // simultaneous request: write wins; a read pulsed mid-transfer must be dropped
    issue(1'b1, 1'b1, 13'h0010, 32'hA5A55A5A);
    repeat (40) @(negedge clk);
    req_read = 1'b1; addr = 13'h0020;
    @(negedge clk);
    req_read = 1'b0;

    issue(1'b0, 1'b1, 13'h1FFE, 32'h11223344);
    issue(1'b1, 1'b0, 13'h1FFE, 32'h0);
    wait_idle();
    check("wrap_1ffe", 80'(dev_mem[13'h1FFE]), 80'h44);
    check("wrap_1fff", 80'(dev_mem[13'h1FFF]), 80'h33);
    check("wrap_0000", 80'(dev_mem[13'h0000]), 80'h22);
    check("wrap_0001", 80'(dev_mem[13'h0001]), 80'h11);
    check("wrap_rdata", 80'(rdata), 80'h11223344);

    // reset during the ADDR phase of a write
    issue(1'b0, 1'b1, 13'h0200, 32'hCAFEF00D);
    repeat (80) @(negedge clk);
    skip_frame = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs", 80'(spi_cs), 80'd1);
    check("abort_sck", 80'(spi_sck), 80'd0);
    check("abort_busy", 80'(busy), 80'd0);
    check("abort_mem_write", 80'(mem_write), 80'd0);
    void'(exp_q.pop_back());
    last_rd = 32'h0;
    repeat (3) @(negedge clk);
    frames.delete();
    rst_n = 1'b1;
    @(negedge clk);
    skip_frame = 1'b0;
    check("rdata_after_reset", 80'(rdata), 80'd0);
    mism = 0;
    for (int i = 0; i < 8192; i++) if (dev_mem[i] !== ref_mem[i]) mism++;
    check("mem_unchanged_after_abort", 80'(mism), 80'd0);
    issue(1'b1, 1'b0, 13'h0100, 32'h0);
    wait_idle();
    check("read_after_reset", 80'(rdata), 80'hDEADBEEF);

    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 3) == 0) ra = 13'h1FFD + 13'($urandom_range(0, 2));
      else ra = 13'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) issue(1'b0, 1'b1, ra, $urandom);
      else issue(1'b1, 1'b0, ra, 32'h0);
    end
    wait_idle();
    repeat (5) @(negedge clk);
    check("no_pending_txn", 80'(exp_q.size()), 80'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
